// File: rtl/riscv_lsu.sv
// Load/store unit between execute and the riscv_ram data port: one request at a time,
// sign/zero-extended loads, SB/SH done as read-modify-write of a full word.
module riscv_lsu #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic                   mem_write_en,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic [WORD_LENGTH-1:0] mem_dout
);
  localparam logic MEM_WRITE = 1'b1;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   we_q;
  logic [2:0]             f3_q;
  logic [WORD_LENGTH-1:0] addr_q, wdata_q, merge_q, rdata_q;
  logic                   err_q;

  logic                   f3_ok, align_ok, in_range, req_ok;
  logic [WORD_LENGTH-1:0] shifted, load_data, merged;
  logic                   wr_cycle;

  // Legality of the incoming request, evaluated in IDLE before latching
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    case (req_funct3)
      F3_B:  begin f3_ok = 1'b1;    align_ok = 1'b1;                   end
      F3_H:  begin f3_ok = 1'b1;    align_ok = ~req_addr[0];           end
      F3_W:  begin f3_ok = 1'b1;    align_ok = (req_addr[1:0] == 2'b00); end
      F3_BU: begin f3_ok = ~req_we; align_ok = 1'b1;                   end
      F3_HU: begin f3_ok = ~req_we; align_ok = ~req_addr[0];           end
      default: ;
    endcase
    // aligned+3 < NUM_MEM, written without the +3 so it cannot wrap
    in_range = {req_addr[WORD_LENGTH-1:2], 2'b00} < WORD_LENGTH'(NUM_MEM - 3);
    req_ok   = f3_ok & align_ok & in_range;
  end

  always_comb begin
    shifted   = mem_dout >> {addr_q[1:0], 3'b000};
    load_data = '0;
    case (f3_q)
      F3_B:  load_data = {{(WORD_LENGTH-8){shifted[7]}}, shifted[7:0]};
      F3_H:  load_data = {{(WORD_LENGTH-16){shifted[15]}}, shifted[15:0]};
      F3_W:  load_data = mem_dout;
      F3_BU: load_data = {{(WORD_LENGTH-8){1'b0}}, shifted[7:0]};
      F3_HU: load_data = {{(WORD_LENGTH-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
    merged = mem_dout;
    if (f3_q == F3_H) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else              merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_ok ? ACCESS : RESP;
      ACCESS:  state_d = (we_q && f3_q != F3_W) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          if (!req_ok) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        // response registers only change on entry to RESP so they hold between responses
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_data;
            err_q   <= 1'b0;
          end else if (f3_q == F3_W) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end else begin
            merge_q <= merged;
          end
        end
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wr_cycle     = ((state_q == ACCESS) && we_q && (f3_q == F3_W)) || (state_q == WRITE);
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign mem_addr     = {addr_q[WORD_LENGTH-1:2], 2'b00};
  assign mem_write_en = (wr_cycle && !rst) ? MEM_WRITE : ~MEM_WRITE;
  assign mem_wdata    = (wr_cycle && !rst) ? ((state_q == WRITE) ? merge_q : wdata_q) : '0;
endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu with a behavioural 128-byte word RAM.
module tb_riscv_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_dout;
  logic        mem_write_en;

  riscv_lsu #(.WORD_LENGTH(32), .NUM_MEM(128)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_write_en && mem_addr < 32'd128) mem[mem_addr[6:2]] <= mem_wdata;
  end
  assign mem_dout = (mem_addr < 32'd128) ? mem[mem_addr[6:2]] : 32'h0;

  typedef struct { logic [31:0] rdata; logic err; int due; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, wr_cnt = 0, last_wr = -1, cur_t = 0;

  // Monitor: count RAM write cycles and score every response against the queue
  always @(negedge clk) begin
    exp_t e;
    if (mem_write_en) begin wr_cnt = wr_cnt + 1; last_wr = cyc; end
    if (resp_valid) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_resp cyc=%0d rdata=%h err=%b", cyc, resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err || cyc !== e.due) begin
          errors = errors + 1;
          $display("FAIL resp got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                   resp_rdata, resp_err, cyc, e.rdata, e.err, e.due);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = a[6:2]; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    cur_t = cyc;
    sb.push_back('{exp_rd, exp_err, cyc + lat});
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL busy_ready got=%b want=0 addr=%h", req_ready, a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] a, input logic [31:0] want);
    checks++;
    if (mem[a[6:2]] !== want) begin
      errors++; $display("FAIL %s got=%h want=%h", name, mem[a[6:2]], want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b rd=%h err=%b addr=%h wd=%h we=%b want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write_en);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    preload(32'h10, 32'h807F_FF80);
    req(0, 3'b000, 32'h10, 0, 32'hFFFF_FF80, 0, 2); drain();
    req(0, 3'b100, 32'h10, 0, 32'h0000_0080, 0, 2); drain();
    req(0, 3'b001, 32'h12, 0, 32'hFFFF_807F, 0, 2); drain();
    req(0, 3'b101, 32'h12, 0, 32'h0000_807F, 0, 2); drain();
    req(0, 3'b010, 32'h10, 0, 32'h807F_FF80, 0, 2); drain();
    req(0, 3'b000, 32'h13, 0, 32'hFFFF_FF80, 0, 2); drain();
    req(0, 3'b100, 32'h11, 0, 32'h0000_00FF, 0, 2); drain();
    req(0, 3'b001, 32'h10, 0, 32'hFFFF_FF80, 0, 2); drain();
  endtask

  task automatic test_sub_word_stores();
    int w0;
    preload(32'h20, 32'h1122_3344);
    w0 = wr_cnt;
    req(1, 3'b000, 32'h21, 32'hFFFF_FFAB, 32'h0, 0, 3); drain();
    chk_word("sb_word", 32'h20, 32'h1122_AB44);
    chk_int("sb_writes", wr_cnt - w0, 1);
    chk_int("sb_write_cyc", last_wr, cur_t + 2);
    w0 = wr_cnt;
    req(1, 3'b001, 32'h22, 32'h1234_BEEF, 32'h0, 0, 3); drain();
    chk_word("sh_word", 32'h20, 32'hBEEF_AB44);
    chk_int("sh_writes", wr_cnt - w0, 1);
  endtask

  task automatic test_sw();
    int w0;
    w0 = wr_cnt;
    req(1, 3'b010, 32'h30, 32'hDEAD_BEEF, 32'h0, 0, 2); drain();
    chk_int("sw_writes", wr_cnt - w0, 1);
    chk_int("sw_write_cyc", last_wr, cur_t + 1);
    req(0, 3'b010, 32'h30, 0, 32'hDEAD_BEEF, 0, 2); drain();
  endtask

  task automatic test_errors();
    int w0;
    w0 = wr_cnt;
    req(0, 3'b010, 32'h31, 0, 32'h0, 1, 1); drain();
    req(1, 3'b001, 32'h23, 32'h5555, 32'h0, 1, 1); drain();
    req(0, 3'b001, 32'h7F, 0, 32'h0, 1, 1); drain();
    req(0, 3'b011, 32'h10, 0, 32'h0, 1, 1); drain();
    req(1, 3'b100, 32'h20, 32'h77, 32'h0, 1, 1); drain();
    req(1, 3'b011, 32'h20, 32'h77, 32'h0, 1, 1); drain();
    chk_int("err_writes", wr_cnt - w0, 0);
    chk_word("err_ram_unchanged", 32'h20, 32'hBEEF_AB44);
  endtask

  task automatic test_range();
    preload(32'h7C, 32'h0102_0304);
    req(0, 3'b010, 32'h7C, 0, 32'h0102_0304, 0, 2); drain();
    req(0, 3'b010, 32'h80, 0, 32'h0, 1, 1); drain();
    req(1, 3'b010, 32'h80, 32'hFFFF_FFFF, 32'h0, 1, 1); drain();
  endtask

  task automatic test_reset_mid_write();
    preload(32'h40, 32'h5566_7788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h40; req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write_en !== 1'b1) begin
      errors++; $display("FAIL rmw_write_phase got=%b want=1", mem_write_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_write_en !== 1'b0) begin
      errors++; $display("FAIL rst_gates_write got=%b want=0", mem_write_en);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        mem_addr !== 32'h0 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_rmw_reset got rdy=%b vld=%b rd=%h err=%b addr=%h we=%b want 1 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_en);
    end
    rst = 1'b0;
    chk_word("rst_ram_unchanged", 32'h40, 32'h5566_7788);
    req(0, 3'b010, 32'h40, 0, 32'h5566_7788, 0, 2); drain();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sub_word_stores();
    test_sw();
    test_errors();
    test_range();
    test_reset_mid_write();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
